// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle HI/LO multiply/divide controller
// Latches operands on issue, holds busy for a fixed latency, then commits HI/LO.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic [1:0]          r_op;

  logic                w_issue;
  logic                w_launch;
  logic                w_done;
  logic                w_div0;
  logic                w_sdiv;
  logic signed [63:0]  w_prod_s;
  logic [63:0]         w_prod_u;
  logic [31:0]         w_abs_a;
  logic [31:0]         w_abs_b;
  logic [31:0]         w_dvd;
  logic [31:0]         w_dvs;
  logic [31:0]         w_uq;
  logic [31:0]         w_ur;
  logic [31:0]         w_q;
  logic [31:0]         w_r;
  logic [63:0]         w_res;

  assign w_issue  = (r_state == IDLE) && start && !cancel;
  assign w_launch = w_issue && !mdop[2];
  assign w_done   = (r_state == RUN) && (r_cnt == CW'(1));
  assign busy     = (r_state == RUN);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_next = RUN;
      RUN:     if (w_done)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Division works on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  assign w_prod_s = $signed(r_a) * $signed(r_b);
  assign w_prod_u = {32'b0, r_a} * {32'b0, r_b};
  assign w_sdiv   = (r_op == 2'd2);
  assign w_div0   = r_op[1] && (r_b == 32'd0);
  assign w_abs_a  = r_a[31] ? (32'd0 - r_a) : r_a;
  assign w_abs_b  = r_b[31] ? (32'd0 - r_b) : r_b;
  assign w_dvd    = w_sdiv ? w_abs_a : r_a;
  assign w_dvs    = (r_b == 32'd0) ? 32'd1 : (w_sdiv ? w_abs_b : r_b);
  assign w_uq     = w_dvd / w_dvs;
  assign w_ur     = w_dvd % w_dvs;
  assign w_q      = (w_sdiv && (r_a[31] ^ r_b[31])) ? (32'd0 - w_uq) : w_uq;
  assign w_r      = (w_sdiv && r_a[31]) ? (32'd0 - w_ur) : w_ur;

  always_comb begin
    w_res = {w_r, w_q};
    case (r_op)
      2'd0:    w_res = w_prod_s;
      2'd1:    w_res = w_prod_u;
      default: w_res = {w_r, w_q};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (w_launch) begin
        r_a   <= a;
        r_b   <= b;
        r_op  <= mdop[1:0];
        r_cnt <= mdop[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (w_issue && mdop == 3'd4) begin
        hi <= a;
      end else if (w_issue && mdop == 3'd5) begin
        lo <= a;
      end
      if (r_state == RUN) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_done && !w_div0) begin
          hi <= w_res[63:32];
          lo <= w_res[31:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl
// Expected HI/LO and latency are queued at issue and checked when busy drops.
module tb_muldiv_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          total = 0;
  int          bad   = 0;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = {32'b0, x};
    longint unsigned uy = {32'b0, y};
    longint          sq;
    longint          sr;
    logic [63:0]     r;
    case (op)
      3'd0: r = sx * sy;
      3'd1: r = ux * uy;
      3'd2: begin
        if (y == 0) r = {m_hi, m_lo};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (y == 0) r = {m_hi, m_lo};
        else r = {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
    return r;
  endfunction

  // Called at a negedge while the DUT is idle; returns at the following negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic c);
    exp_t e;
    start = 1'b1; mdop = op; a = x; b = y; cancel = c;
    if (!c) begin
      if (op < 3'd4) begin
        e.res = model(op, x, y);
        e.cyc = (op < 3'd2) ? MC : DC;
        sb_q.push_back(e);
        {m_hi, m_lo} = e.res;
      end else if (op == 3'd4) m_hi = x;
      else if (op == 3'd5) m_lo = x;
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int pre);
    int   n = pre;
    exp_t e;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_cyc"}, 64'(n), 64'(e.cyc));
    chk({tag, "_hilo"}, {hi, lo}, e.res);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdop = 3'd0; a = '0; b = '0; cancel = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    start = 1'b1; mdop = 3'd4; a = 32'hDEAD0000;
    @(negedge clk);
    chk("rst_start_ign", {hi, lo}, 64'd0);
    start = 1'b0;
    reset = 1'b0;

    issue(3'd0, 32'hFFFFFFFF, 32'h2, 1'b0);
    wait_done("mult", 0);
    chk("mult_spec", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);

    issue(3'd1, 32'hFFFFFFFF, 32'h2, 1'b0);
    wait_done("multu", 0);
    chk("multu_spec", {hi, lo}, 64'h00000001_FFFFFFFE);

    issue(3'd2, 32'hFFFFFFF9, 32'h2, 1'b0);
    wait_done("div", 0);
    chk("div_spec", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    issue(3'd2, 32'h1234, 32'h0, 1'b0);
    wait_done("div0", 0);
    issue(3'd3, 32'h55, 32'h0, 1'b0);
    wait_done("divu0", 0);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_done("div_ovf", 0);
    chk("div_ovf_spec", {hi, lo}, 64'h00000000_80000000);

    issue(3'd4, 32'h12345678, 32'h0, 1'b0);
    chk("mthi_busy", {63'b0, busy}, 64'd0);
    chk("mthi_hi", {32'b0, hi}, {32'b0, m_hi});
    chk("mthi_spec", {32'b0, hi}, 64'h12345678);
    issue(3'd5, 32'hCAFEF00D, 32'h0, 1'b1);
    chk("mtlo_cancel", {hi, lo}, {m_hi, m_lo});
    issue(3'd5, 32'h0BADBEEF, 32'h0, 1'b0);
    chk("mtlo", {hi, lo}, {m_hi, m_lo});
    issue(3'd0, 32'h7, 32'h9, 1'b1);
    chk("cancel_start", {63'b0, busy}, 64'd0);
    issue(3'd6, 32'h7, 32'h9, 1'b0);
    issue(3'd7, 32'h7, 32'h9, 1'b0);
    chk("nop67", {31'b0, busy, hi}, {32'b0, m_hi});
    chk("nop67_lo", {32'b0, lo}, {32'b0, m_lo});

    // divu issued 3 cycles into a mult, with a changed mid-run
    issue(3'd0, 32'hFFFF0001, 32'h00030005, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; mdop = 3'd3; a = 32'h99; b = 32'h3;
    @(negedge clk);
    start = 1'b0; a = 32'h11111111;
    wait_done("run_ignore", 3);
    chk("run_ignore_idle", {63'b0, busy}, 64'd0);

    // back-to-back: issued in the first idle cycle, cancel held during RUN
    issue(3'd3, 32'hFFFFFFFF, 32'h7, 1'b0);
    cancel = 1'b1;
    wait_done("divu_cancel_run", 0);
    cancel = 1'b0;
    issue(3'd1, 32'h89ABCDEF, 32'h12345678, 1'b0);
    chk("b2b_busy", {63'b0, busy}, 64'd1);
    wait_done("b2b", 0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op = 3'($urandom_range(0, 3));
      logic [31:0] x  = $urandom;
      logic [31:0] y  = (i == 5) ? 32'h0 : $urandom;
      issue(op, x, y, 1'b0);
      wait_done("rand", 0);
    end

    // reset in cycle 4 of a div
    issue(3'd2, 32'h1000, 32'h7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_run_busy", {63'b0, busy}, 64'd0);
    chk("rst_run_hilo", {hi, lo}, 64'd0);
    sb_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    issue(3'd0, 32'h3, 32'hFFFFFFFB, 1'b0);
    chk("post_rst_busy", {63'b0, busy}, 64'd1);
    wait_done("post_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
